frogger_game_seq: RTL and testbench
===================================

# frogger_game_seq

Game-level sequencer for the Frogger datapath. Drives the frog controller's game-active enable and a respawn pulse. Owns lives, the round countdown, homes-filled count and level. Sits between the debounced start switch, the collision and lily-pad detectors, and the frog controller and score/HUD display logic.

## Interface
- c_TICK_COUNT, 25000000: clocks per one-second game tick (25 MHz board clock).
- c_START_LIVES, 3: lives loaded at game start (1..3).
- c_ROUND_TIME, 60: round countdown in ticks (1..127).
- c_HOLD_TICKS, 2: ticks spent in DYING and WIN before resuming.
- c_WIN_HOMES, 5: lily-pad arrivals that complete a level (1..7).
- i_Clk  in  1  system clock.
- i_Rst_N  in  1  asynchronous active-low reset.
- i_Start  in  1  debounced start switch, level.
- i_Collided  in  1  collision strobe from the collision detector.
- i_Home  in  1  one-cycle strobe: the frog landed on a lily pad.
- o_Game_Active  out  1  enable to the frog controller; high only in PLAY.
- o_Respawn  out  1  one-cycle pulse: return the frog to its origin.
- o_Lives  out  2  remaining lives.
- o_Time_Left  out  7  round seconds remaining.
- o_Level  out  4  completed levels, saturating.
- o_Game_Over  out  1  high in GAME_OVER.
- o_State  out  3  current state encoding, for HUD/debug.

## Operation
- Reset values:
  - State IDLE.
  - o_Game_Active=0, o_Respawn=0, o_Lives=c_START_LIVES, o_Time_Left=c_ROUND_TIME, o_Level=0, o_Game_Over=0.
  - Homes counter 0, tick counter 0.
- i_Start is rising-edge detected internally with one registered copy. A held switch does not retrigger.
- IDLE / GAME_OVER -> PLAY on a start edge:
  - Load lives, time and homes.
  - Clear the level.
  - Clear the tick counter.
  - Pulse o_Respawn.
- PLAY:
  - The tick counter advances. Each wrap at c_TICK_COUNT-1 decrements o_Time_Left.
  - i_Collided -> DYING. Lives decrement by 1 on the transition.
  - i_Home -> homes+1. If the new count equals c_WIN_HOMES, go to WIN. Otherwise pulse o_Respawn and stay in PLAY.
- DYING: hold for c_HOLD_TICKS ticks.
  - If lives==0, go to GAME_OVER.
  - Otherwise go to PLAY, reload time, clear the tick counter and pulse o_Respawn.
- WIN: hold for c_HOLD_TICKS ticks.
  - Level saturating +1 (stays at 15).
  - Homes cleared.
  - Go to PLAY, reload time, pulse o_Respawn.
- GAME_OVER: o_Game_Over=1. The only exit is a start edge.
- Priority in PLAY, same cycle: collision > time-out > home. Collision and home together count as a death only; the home is discarded.
- i_Collided and i_Home are ignored outside PLAY.
- A start edge in PLAY, DYING or WIN has no effect.
- Lives never underflow. Decrement happens only from PLAY, and lives is never 0 while in PLAY.

## Timing
- All outputs are registered.
- o_Game_Active falls the cycle after a collision or home-to-WIN strobe.
- o_Respawn is asserted exactly one cycle, on the cycle the state register enters PLAY. It also pulses on a non-final home in PLAY.
- DYING/WIN duration is c_HOLD_TICKS × c_TICK_COUNT clocks, ±0. The tick counter is cleared on entry.
- Time-out: o_Time_Left reaches 0 on a tick wrap. The next cycle behaves as a collision (-> DYING, lives-1).
- Asserting i_Rst_N low mid-operation returns every output to its reset value immediately, regardless of state.

## Configuration
- FROGGER_ROUND_TIMER_EN defined:
  - Countdown active as described.
  - Time-out kills the frog.
- Undefined:
  - o_Time_Left is held at c_ROUND_TIME.
  - No time-out path.
  - Tick counter used only for hold states.

## Structure
- Shared package frogger_pkg carries:
  - State encodings: IDLE=0, PLAY=1, DYING=2, WIN=3, GAME_OVER=4.
  - The lives, time and level widths.
  - The default c_ constants.
- One natural sub-module: frogger_tick_gen.
  - Prescaler with synchronous clear.
  - Emits a one-cycle tick at c_TICK_COUNT.
- The FSM, counters and edge detect live in the top.

## Test plan
Bench parameters: c_TICK_COUNT=4, c_ROUND_TIME=3, c_HOLD_TICKS=1, c_WIN_HOMES=2, c_START_LIVES=3.
- Reset, then a start edge -> PLAY, o_Respawn pulse for 1 cycle, o_Game_Active=1, o_Lives=3, o_Time_Left=3.
- Collision in PLAY -> o_Lives=2, DYING for 4 clocks, then PLAY with o_Respawn pulse and o_Time_Left=3.
- Two i_Home strobes -> first gives a respawn pulse. Second gives WIN, then PLAY with o_Level=1 and homes=0.
- Timer on, no input for 12 clocks -> o_Time_Left 3→0, then DYING, o_Lives=2. With the macro undefined, o_Time_Left stays 3.
- Three deaths -> GAME_OVER, o_Game_Over=1, o_Lives=0. A start edge restores PLAY with o_Lives=3 and o_Level=0.
- i_Collided and i_Home asserted on the same cycle -> death only, homes unchanged. Reset asserted mid-DYING -> IDLE with all reset values.

Source files
------------

// File: rtl/frogger_pkg.sv
// Shared types and widths for the Frogger game sequencer: state encodings,
// counter widths and the default board-level constants.
package frogger_pkg;

  localparam int LIVES_W = 2;
  localparam int TIME_W  = 7;
  localparam int LEVEL_W = 4;
  localparam int HOMES_W = 3;
  localparam int STATE_W = 3;

  localparam int c_DEF_TICK_COUNT  = 25000000;
  localparam int c_DEF_START_LIVES = 3;
  localparam int c_DEF_ROUND_TIME  = 60;
  localparam int c_DEF_HOLD_TICKS  = 2;
  localparam int c_DEF_WIN_HOMES   = 5;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 3'd0,
    S_PLAY      = 3'd1,
    S_DYING     = 3'd2,
    S_WIN       = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  function automatic logic [LEVEL_W-1:0] level_sat_inc(input logic [LEVEL_W-1:0] lvl);
    return (&lvl) ? lvl : lvl + LEVEL_W'(1);
  endfunction

endpackage

// File: rtl/frogger_tick_gen.sv
// Game-tick prescaler: counts enabled clocks and flags the last count of each
// TICK_COUNT-clock period. Synchronous clear restarts the period.
module frogger_tick_gen #(
  parameter int TICK_COUNT = 4
) (
  input  logic i_Clk,
  input  logic i_Rst_N,
  input  logic i_En,
  input  logic i_Clr,
  output logic o_Tick
);

  localparam int CNT_W = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_COUNT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_Clr)     cnt_d = '0;
    else if (i_En) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // Combinational off the counter flop so the sequencer sees the wrap cycle.
  assign o_Tick = i_En & (cnt_q == LAST);

endmodule

// File: rtl/frogger_game_seq.sv
// Frogger game sequencer: lives, round countdown, homes, level and the
// frog controller enable/respawn. Round timer enabled by FROGGER_ROUND_TIMER_EN.
module frogger_game_seq import frogger_pkg::*; #(
  parameter int c_TICK_COUNT  = c_DEF_TICK_COUNT,
  parameter int c_START_LIVES = c_DEF_START_LIVES,
  parameter int c_ROUND_TIME  = c_DEF_ROUND_TIME,
  parameter int c_HOLD_TICKS  = c_DEF_HOLD_TICKS,
  parameter int c_WIN_HOMES   = c_DEF_WIN_HOMES
) (
  input  logic               i_Clk,
  input  logic               i_Rst_N,
  input  logic               i_Start,
  input  logic               i_Collided,
  input  logic               i_Home,
  output logic               o_Game_Active,
  output logic               o_Respawn,
  output logic [LIVES_W-1:0] o_Lives,
  output logic [TIME_W-1:0]  o_Time_Left,
  output logic [LEVEL_W-1:0] o_Level,
  output logic               o_Game_Over,
  output logic [STATE_W-1:0] o_State
);

  localparam int HOLD_W = $clog2(c_HOLD_TICKS + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(c_HOLD_TICKS - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(c_START_LIVES);
  localparam logic [TIME_W-1:0]  TIME_INIT  = TIME_W'(c_ROUND_TIME);
  localparam logic [HOMES_W-1:0] HOMES_WIN  = HOMES_W'(c_WIN_HOMES);

  state_t             state_q, state_d;
  logic               start_q;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [TIME_W-1:0]  time_q, time_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [HOMES_W-1:0] homes_q, homes_d, homes_inc;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               respawn_q, respawn_d;
  logic               game_active_q, game_over_q;
  logic               tick, tick_en, tick_clr, start_edge, timeout, hold_done;

  assign start_edge = i_Start & ~start_q;
  assign homes_inc  = homes_q + HOMES_W'(1);
  assign hold_done  = tick && (hold_q == HOLD_LAST);

`ifdef FROGGER_ROUND_TIMER_EN
  assign tick_en = (state_q == S_PLAY) || (state_q == S_DYING) || (state_q == S_WIN);
  assign timeout = (time_q == '0);
`else
  assign tick_en = (state_q == S_DYING) || (state_q == S_WIN);
  assign timeout = 1'b0;
`endif

  frogger_tick_gen #(.TICK_COUNT(c_TICK_COUNT)) u_tick (
    .i_Clk  (i_Clk),
    .i_Rst_N(i_Rst_N),
    .i_En   (tick_en),
    .i_Clr  (tick_clr),
    .o_Tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    time_d    = time_q;
    level_d   = level_q;
    homes_d   = homes_q;
    hold_d    = hold_q;
    respawn_d = 1'b0;
    tick_clr  = 1'b0;
    case (state_q)
      S_IDLE, S_GAME_OVER: begin
        if (start_edge) begin
          state_d   = S_PLAY;
          lives_d   = LIVES_INIT;
          time_d    = TIME_INIT;
          homes_d   = '0;
          level_d   = '0;
          tick_clr  = 1'b1;
          respawn_d = 1'b1;
        end
      end
      S_PLAY: begin
`ifdef FROGGER_ROUND_TIMER_EN
        if (tick && time_q != '0) time_d = time_q - TIME_W'(1);
`endif
        // Collision outranks time-out, which outranks a same-cycle home.
        if (i_Collided || timeout) begin
          state_d  = S_DYING;
          if (lives_q != '0) lives_d = lives_q - LIVES_W'(1);
          hold_d   = '0;
          tick_clr = 1'b1;
        end else if (i_Home) begin
          homes_d = homes_inc;
          if (homes_inc == HOMES_WIN) begin
            state_d  = S_WIN;
            hold_d   = '0;
            tick_clr = 1'b1;
          end else begin
            respawn_d = 1'b1;
          end
        end
      end
      S_DYING: begin
        if (hold_done) begin
          if (lives_q == '0) begin
            state_d = S_GAME_OVER;
          end else begin
            state_d   = S_PLAY;
            time_d    = TIME_INIT;
            tick_clr  = 1'b1;
            respawn_d = 1'b1;
          end
        end else if (tick) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      S_WIN: begin
        if (hold_done) begin
          state_d   = S_PLAY;
          level_d   = level_sat_inc(level_q);
          homes_d   = '0;
          time_d    = TIME_INIT;
          tick_clr  = 1'b1;
          respawn_d = 1'b1;
        end else if (tick) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      state_q       <= S_IDLE;
      start_q       <= 1'b0;
      lives_q       <= LIVES_INIT;
      time_q        <= TIME_INIT;
      level_q       <= '0;
      homes_q       <= '0;
      hold_q        <= '0;
      respawn_q     <= 1'b0;
      game_active_q <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_q       <= i_Start;
      lives_q       <= lives_d;
      time_q        <= time_d;
      level_q       <= level_d;
      homes_q       <= homes_d;
      hold_q        <= hold_d;
      respawn_q     <= respawn_d;
      game_active_q <= (state_d == S_PLAY);
      game_over_q   <= (state_d == S_GAME_OVER);
    end
  end

  assign o_Game_Active = game_active_q;
  assign o_Respawn     = respawn_q;
  assign o_Lives       = lives_q;
  assign o_Time_Left   = time_q;
  assign o_Level       = level_q;
  assign o_Game_Over   = game_over_q;
  assign o_State       = state_q;

endmodule

// File: tb/tb_frogger_game_seq.sv
// Scoreboard bench for frogger_game_seq with a 4-clock tick, 3-tick round,
// 1-tick hold and 2 homes per level. Follows FROGGER_ROUND_TIMER_EN if defined.
module tb_frogger_game_seq;

  localparam int RTIME = 3;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_PLAY = 3'd1, ST_DYING = 3'd2,
                         ST_WIN  = 3'd3, ST_GO   = 3'd4;
`ifdef FROGGER_ROUND_TIMER_EN
  localparam bit TMR = 1'b1;
`else
  localparam bit TMR = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] st;
    logic       act;
    logic       rsp;
    logic [1:0] lives;
    logic [6:0] tl;
    logic [3:0] lvl;
    logic       over;
  } out_t;

  typedef struct {
    string tag;
    out_t  v;
  } sb_t;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, col = 1'b0, home = 1'b0;
  logic       o_Game_Active, o_Respawn, o_Game_Over;
  logic [1:0] o_Lives;
  logic [6:0] o_Time_Left;
  logic [3:0] o_Level;
  logic [2:0] o_State;
  out_t       obs;
  sb_t        sb[$];
  int         n_chk = 0, n_fail = 0;

  frogger_game_seq #(
    .c_TICK_COUNT(4), .c_START_LIVES(3), .c_ROUND_TIME(RTIME),
    .c_HOLD_TICKS(1), .c_WIN_HOMES(2)
  ) dut (
    .i_Clk(clk), .i_Rst_N(rst_n), .i_Start(start), .i_Collided(col), .i_Home(home),
    .o_Game_Active(o_Game_Active), .o_Respawn(o_Respawn), .o_Lives(o_Lives),
    .o_Time_Left(o_Time_Left), .o_Level(o_Level), .o_Game_Over(o_Game_Over),
    .o_State(o_State)
  );

  always #5 clk = ~clk;

  assign obs = {o_State, o_Game_Active, o_Respawn, o_Lives, o_Time_Left, o_Level, o_Game_Over};

  function automatic out_t ex(logic [2:0] st, logic rsp, int lives, int tl, int lvl);
    out_t r;
    r.st = st; r.act = (st == ST_PLAY); r.rsp = rsp; r.lives = 2'(lives);
    r.tl = 7'(tl); r.lvl = 4'(lvl); r.over = (st == ST_GO);
    return r;
  endfunction

  function automatic int tm(int v);
    return TMR ? v : RTIME;
  endfunction

  function automatic string fmt(out_t v);
    return $sformatf("st=%0d act=%0d rsp=%0d lives=%0d time=%0d lvl=%0d over=%0d",
                     v.st, v.act, v.rsp, v.lives, v.tl, v.lvl, v.over);
  endfunction

  task automatic push(string tag, out_t v);
    sb_t s;
    s.tag = tag; s.v = v;
    sb.push_back(s);
  endtask

  task automatic test_reset();
    sb_t s;
    rst_n = 1'b0; {start, col, home} = 3'b000;
    push("reset_hold", ex(ST_IDLE, 0, 3, 3, 0));
    repeat (2) @(posedge clk);
    #1;
    s = sb.pop_front(); n_chk++;
    if (obs !== s.v) begin n_fail++; $display("FAIL %s: got %s want %s", s.tag, fmt(obs), fmt(s.v)); end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push($sformatf("reset_idle[%0d]", i), ex(ST_IDLE, 0, 3, 3, 0));
      @(posedge clk); #1;
      s = sb.pop_front(); n_chk++;
      if (obs !== s.v) begin n_fail++; $display("FAIL %s: got %s want %s", s.tag, fmt(obs), fmt(s.v)); end
    end
  endtask

  task automatic test_start();
    logic [2:0] in_v [3];
    out_t       e    [3];
    sb_t        s;
    in_v = '{3'b100, 3'b100, 3'b000};
    e    = '{ex(ST_PLAY, 1, 3, 3, 0), ex(ST_PLAY, 0, 3, 3, 0), ex(ST_PLAY, 0, 3, 3, 0)};
    for (int i = 0; i < 3; i++) begin
      {start, col, home} = in_v[i];
      push($sformatf("start[%0d]", i), e[i]);
      @(posedge clk); #1;
      s = sb.pop_front(); n_chk++;
      if (obs !== s.v) begin n_fail++; $display("FAIL %s: got %s want %s", s.tag, fmt(obs), fmt(s.v)); end
    end
  endtask

  task automatic test_collision();
    logic [2:0] in_v [6];
    out_t       e    [6];
    sb_t        s;
    in_v = '{3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    e    = '{ex(ST_DYING, 0, 2, 3, 0), ex(ST_DYING, 0, 2, 3, 0), ex(ST_DYING, 0, 2, 3, 0),
             ex(ST_DYING, 0, 2, 3, 0), ex(ST_PLAY, 1, 2, 3, 0), ex(ST_PLAY, 0, 2, 3, 0)};
    for (int i = 0; i < 6; i++) begin
      {start, col, home} = in_v[i];
      push($sformatf("collision[%0d]", i), e[i]);
      @(posedge clk); #1;
      s = sb.pop_front(); n_chk++;
      if (obs !== s.v) begin n_fail++; $display("FAIL %s: got %s want %s", s.tag, fmt(obs), fmt(s.v)); end
    end
  endtask

  task automatic test_homes();
    logic [2:0] in_v [11];
    out_t       e    [11];
    sb_t        s;
    in_v = '{3'b001, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
             3'b001, 3'b000};
    e    = '{ex(ST_PLAY, 1, 2, 3, 0), ex(ST_PLAY, 0, 2, 3, 0), ex(ST_PLAY, 0, 2, tm(2), 0),
             ex(ST_WIN, 0, 2, tm(2), 0), ex(ST_WIN, 0, 2, tm(2), 0), ex(ST_WIN, 0, 2, tm(2), 0),
             ex(ST_WIN, 0, 2, tm(2), 0), ex(ST_PLAY, 1, 2, 3, 1), ex(ST_PLAY, 0, 2, 3, 1),
             ex(ST_PLAY, 1, 2, 3, 1), ex(ST_PLAY, 0, 2, 3, 1)};
    for (int i = 0; i < 11; i++) begin
      {start, col, home} = in_v[i];
      push($sformatf("homes[%0d]", i), e[i]);
      @(posedge clk); #1;
      s = sb.pop_front(); n_chk++;
      if (obs !== s.v) begin n_fail++; $display("FAIL %s: got %s want %s", s.tag, fmt(obs), fmt(s.v)); end
    end
  endtask

  task automatic test_game_over();
    logic [2:0] in_v [15];
    out_t       e    [15];
    sb_t        s;
    in_v = '{3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000,
             3'b000, 3'b000, 3'b011, 3'b100, 3'b100, 3'b000};
    e    = '{ex(ST_PLAY, 0, 2, tm(2), 1), ex(ST_DYING, 0, 1, tm(2), 1), ex(ST_DYING, 0, 1, tm(2), 1),
             ex(ST_DYING, 0, 1, tm(2), 1), ex(ST_DYING, 0, 1, tm(2), 1), ex(ST_PLAY, 1, 1, 3, 1),
             ex(ST_DYING, 0, 0, 3, 1), ex(ST_DYING, 0, 0, 3, 1), ex(ST_DYING, 0, 0, 3, 1),
             ex(ST_DYING, 0, 0, 3, 1), ex(ST_GO, 0, 0, 3, 1), ex(ST_GO, 0, 0, 3, 1),
             ex(ST_PLAY, 1, 3, 3, 0), ex(ST_PLAY, 0, 3, 3, 0), ex(ST_PLAY, 0, 3, 3, 0)};
    for (int i = 0; i < 15; i++) begin
      {start, col, home} = in_v[i];
      push($sformatf("game_over[%0d]", i), e[i]);
      @(posedge clk); #1;
      s = sb.pop_front(); n_chk++;
      if (obs !== s.v) begin n_fail++; $display("FAIL %s: got %s want %s", s.tag, fmt(obs), fmt(s.v)); end
    end
  endtask

  // Entered two cycles into a fresh round; a stray start edge at cycle 5 must do nothing.
  task automatic test_timeout();
    sb_t s;
    for (int k = 3; k <= 13; k++) begin
      {start, col, home} = (k == 5) ? 3'b100 : 3'b000;
      if (!TMR)         push($sformatf("timeout[%0d]", k), ex(ST_PLAY, 0, 3, RTIME, 0));
      else if (k < 13)  push($sformatf("timeout[%0d]", k), ex(ST_PLAY, 0, 3, RTIME - k / 4, 0));
      else              push($sformatf("timeout[%0d]", k), ex(ST_DYING, 0, 2, 0, 0));
      @(posedge clk); #1;
      s = sb.pop_front(); n_chk++;
      if (obs !== s.v) begin n_fail++; $display("FAIL %s: got %s want %s", s.tag, fmt(obs), fmt(s.v)); end
    end
  endtask

  task automatic test_reset_mid();
    sb_t s;
    {start, col, home} = 3'b010;
    push("mid_dying", ex(ST_DYING, 0, 2, tm(0), 0));
    @(posedge clk); #1;
    s = sb.pop_front(); n_chk++;
    if (obs !== s.v) begin n_fail++; $display("FAIL %s: got %s want %s", s.tag, fmt(obs), fmt(s.v)); end
    {start, col, home} = 3'b000;
    rst_n = 1'b0;
    push("mid_reset_async", ex(ST_IDLE, 0, 3, 3, 0));
    #2;
    s = sb.pop_front(); n_chk++;
    if (obs !== s.v) begin n_fail++; $display("FAIL %s: got %s want %s", s.tag, fmt(obs), fmt(s.v)); end
    push("mid_reset_held", ex(ST_IDLE, 0, 3, 3, 0));
    @(posedge clk); #1;
    s = sb.pop_front(); n_chk++;
    if (obs !== s.v) begin n_fail++; $display("FAIL %s: got %s want %s", s.tag, fmt(obs), fmt(s.v)); end
    rst_n = 1'b1;
    push("mid_reset_release", ex(ST_IDLE, 0, 3, 3, 0));
    @(posedge clk); #1;
    s = sb.pop_front(); n_chk++;
    if (obs !== s.v) begin n_fail++; $display("FAIL %s: got %s want %s", s.tag, fmt(obs), fmt(s.v)); end
  endtask

  // Home then collision+home: the second home must be dropped, so the next home wins.
  task automatic test_simul();
    logic [2:0] in_v [13];
    out_t       e    [13];
    sb_t        s;
    in_v = '{3'b100, 3'b001, 3'b000, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001,
             3'b000, 3'b000, 3'b000, 3'b000};
    e    = '{ex(ST_PLAY, 1, 3, 3, 0), ex(ST_PLAY, 1, 3, 3, 0), ex(ST_PLAY, 0, 3, 3, 0),
             ex(ST_DYING, 0, 2, 3, 0), ex(ST_DYING, 0, 2, 3, 0), ex(ST_DYING, 0, 2, 3, 0),
             ex(ST_DYING, 0, 2, 3, 0), ex(ST_PLAY, 1, 2, 3, 0), ex(ST_WIN, 0, 2, 3, 0),
             ex(ST_WIN, 0, 2, 3, 0), ex(ST_WIN, 0, 2, 3, 0), ex(ST_WIN, 0, 2, 3, 0),
             ex(ST_PLAY, 1, 2, 3, 1)};
    for (int i = 0; i < 13; i++) begin
      {start, col, home} = in_v[i];
      push($sformatf("simul[%0d]", i), e[i]);
      @(posedge clk); #1;
      s = sb.pop_front(); n_chk++;
      if (obs !== s.v) begin n_fail++; $display("FAIL %s: got %s want %s", s.tag, fmt(obs), fmt(s.v)); end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_collision();
    test_homes();
    test_game_over();
    test_timeout();
    test_reset_mid();
    test_simul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
